// File: rtl/seg_scan_capture.sv
// Receiver for a multiplexed seven-segment bus: synchronises seg/an, waits for each
// digit's dwell to settle, and rebuilds the four displayed digits with frame and stale flags.
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 1000,
  parameter int FRAME_TIMEOUT = 1048576
) (
  input  logic        Clk100M,
  input  logic        reset,
  input  logic [7:0]  segIn,
  input  logic [3:0]  anIn,
  output logic [31:0] digitSeg,
  output logic [15:0] digitVal,
  output logic [3:0]  known,
  output logic        frameDone,
  output logic        stale
);

  localparam logic [15:0] CNT_MAX  = 16'(STABLE_CYCLES - 1);
  localparam logic [24:0] IDLE_LIM = 25'(FRAME_TIMEOUT);

  // {an, seg} travel together through the synchroniser and compare register
  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;
  logic [11:0] prev_q, prev_d;
  logic [15:0] stable_cnt_q, stable_cnt_d;
  logic        captured_q, captured_d;
  logic [3:0]  seen_q, seen_d;
  logic [23:0] idle_q, idle_d;
  logic [31:0] digit_seg_q, digit_seg_d;
  logic [15:0] digit_val_q, digit_val_d;
  logic [3:0]  known_q, known_d;
  logic        frame_done_q, frame_done_d;
  logic        stale_q, stale_d;

  logic        sample_valid;
  logic        cnt_clear;
  logic        cap_fire;
  logic [1:0]  cap_idx;
  logic [4:0]  cap_dec;
  logic [3:0]  seen_tmp;

  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    sync1_d      = {anIn, segIn};
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    stable_cnt_d = stable_cnt_q;
    captured_d   = captured_q;
    seen_d       = seen_q;
    idle_d       = idle_q;
    digit_seg_d  = digit_seg_q;
    digit_val_d  = digit_val_q;
    known_d      = known_q;
    frame_done_d = 1'b0;
    sample_valid = 1'b0;
    cap_idx      = 2'd0;
    seen_tmp     = seen_q;

    case (sync2_q[11:8])
      4'b1110, 4'b1101, 4'b1011, 4'b0111: sample_valid = 1'b1;
      default:                            sample_valid = 1'b0;
    endcase

    // The captured digit comes from prev, which holds the value that was counted stable
    case (prev_q[11:8])
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
    cap_dec = decode_seg(prev_q[6:0]);

    cnt_clear = !sample_valid || (sync2_q != prev_q);
    cap_fire  = (stable_cnt_q == CNT_MAX) && !captured_q;

    if (cap_fire) begin
      captured_d = 1'b1;
      digit_seg_d[{cap_idx, 3'b000} +: 8] = prev_q[7:0];
      digit_val_d[{cap_idx, 2'b00} +: 4]  = cap_dec[3:0];
      known_d[cap_idx] = cap_dec[4];
      seen_tmp = seen_q | (4'b0001 << cap_idx);
      if (seen_tmp == 4'hF) begin
        frame_done_d = 1'b1;
        seen_d       = 4'h0;
      end else begin
        seen_d = seen_tmp;
      end
    end

    if (cnt_clear) begin
      stable_cnt_d = 16'd0;
      captured_d   = 1'b0;
    end else if (stable_cnt_q != CNT_MAX) begin
      stable_cnt_d = stable_cnt_q + 16'd1;
    end

    if (cap_fire) begin
      idle_d = 24'd0;
    end else if (idle_q != 24'hFF_FFFF) begin
      idle_d = idle_q + 24'd1;
    end
    // 25-bit compare so the largest legal timeout (2^24) never asserts
    stale_d = ({1'b0, idle_d} >= IDLE_LIM);
  end

  always_ff @(posedge Clk100M) begin
    if (!reset) begin
      sync1_q      <= 12'hFFF;
      sync2_q      <= 12'hFFF;
      prev_q       <= 12'hFFF;
      stable_cnt_q <= 16'd0;
      captured_q   <= 1'b0;
      seen_q       <= 4'h0;
      idle_q       <= 24'd0;
      digit_seg_q  <= 32'hFFFF_FFFF;
      digit_val_q  <= 16'h0000;
      known_q      <= 4'h0;
      frame_done_q <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      stable_cnt_q <= stable_cnt_d;
      captured_q   <= captured_d;
      seen_q       <= seen_d;
      idle_q       <= idle_d;
      digit_seg_q  <= digit_seg_d;
      digit_val_q  <= digit_val_d;
      known_q      <= known_d;
      frame_done_q <= frame_done_d;
      stale_q      <= stale_d;
    end
  end

  assign digitSeg  = digit_seg_q;
  assign digitVal  = digit_val_q;
  assign known     = known_q;
  assign frameDone = frame_done_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: dwell driver, timestamped capture scoreboard and
// a per-cycle hold check on all outputs between expected captures.
module tb_seg_scan_capture;

  localparam int SC = 8;
  localparam int FT = 16;
  localparam int W  = 85;  // {cycle[31:0], seg[31:0], val[15:0], known[3:0], frame_done}

  logic        clk;
  logic        reset;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [31:0] digit_seg;
  logic [15:0] digit_val;
  logic [3:0]  known;
  logic        frame_done;
  logic        stale;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  logic [W-1:0] exp_q[$];
  logic [52:0]  exp_hold;
  logic [31:0]  m_seg;
  logic [15:0]  m_val;
  logic [3:0]   m_known;
  logic [3:0]   m_seen;

  seg_scan_capture #(.STABLE_CYCLES(SC), .FRAME_TIMEOUT(FT)) dut (
    .Clk100M   (clk),
    .reset     (reset),
    .segIn     (seg_in),
    .anIn      (an_in),
    .digitSeg  (digit_seg),
    .digitVal  (digit_val),
    .known     (known),
    .frameDone (frame_done),
    .stale     (stale)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [7:0] s);
    case (s[6:0])
      7'h40: return 5'h10; 7'h79: return 5'h11; 7'h24: return 5'h12; 7'h30: return 5'h13;
      7'h19: return 5'h14; 7'h12: return 5'h15; 7'h02: return 5'h16; 7'h78: return 5'h17;
      7'h00: return 5'h18; 7'h10: return 5'h19; 7'h08: return 5'h1A; 7'h03: return 5'h1B;
      7'h46: return 5'h1C; 7'h21: return 5'h1D; 7'h06: return 5'h1E; 7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // driver tasks
  task automatic start_dwell(input logic [3:0] an, input logic [7:0] sg, input bit cap);
    int idx;
    bit valid;
    logic [4:0] d;
    logic fd;
    an_in  = an;
    seg_in = sg;
    valid  = 1'b1;
    idx    = 0;
    case (an)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: valid = 1'b0;
    endcase
    if (cap && valid) begin
      d = ref_decode(sg);
      m_seg[idx*8 +: 8] = sg;
      m_val[idx*4 +: 4] = d[3:0];
      m_known[idx]      = d[4];
      m_seen[idx]       = 1'b1;
      fd = (m_seen == 4'hF);
      if (fd) m_seen = 4'h0;
      exp_q.push_back({32'(cyc + SC + 3), m_seg, m_val, m_known, fd});
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dwell(input logic [3:0] an, input logic [7:0] sg, input int n);
    start_dwell(an, sg, n >= SC);
    wait_cycles(n);
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    @(negedge clk);
    while (cyc != target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) check("wait_timeout", 64'(cyc), 64'(target));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    an_in    = 4'hF;
    seg_in   = 8'hFF;
    m_seg    = 32'hFFFF_FFFF;
    m_val    = 16'h0;
    m_known  = 4'h0;
    m_seen   = 4'h0;
    exp_hold = {32'hFFFF_FFFF, 16'h0, 4'h0, 1'b0};
    mon_en   = 1'b1;
  endtask

  // scoreboard: pop at the expected capture cycle, otherwise outputs must hold
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q[0];
      else e = '0;
      if (exp_q.size() > 0 && e[84:53] == 32'(cyc)) begin
        void'(exp_q.pop_front());
        check("cap_seg",   64'(digit_seg),  64'(e[52:21]));
        check("cap_val",   64'(digit_val),  64'(e[20:5]));
        check("cap_known", 64'(known),      64'(e[4:1]));
        check("cap_frame", 64'(frame_done), 64'(e[0]));
        exp_hold = {e[52:1], 1'b0};
      end else begin
        check("hold", 64'({digit_seg, digit_val, known, frame_done}), 64'(exp_hold));
      end
    end
  end

  initial begin
    int r;
    int d;
    reset  = 1'b0;
    an_in  = 4'b1110;
    seg_in = 8'h40;

    // reset values with a valid digit presented on the pins
    do_reset();
    @(negedge clk);
    check("rst_seg",   64'(digit_seg),  64'hFFFF_FFFF);
    check("rst_val",   64'(digit_val),  64'h0);
    check("rst_known", 64'(known),      64'h0);
    check("rst_frame", 64'(frame_done), 64'h0);
    check("rst_stale", 64'(stale),      64'h0);
    @(posedge clk);
    #1;

    // full frame 4321
    dwell(4'b1110, 8'h79, 20);
    dwell(4'b1101, 8'h24, 20);
    dwell(4'b1011, 8'h30, 20);
    dwell(4'b0111, 8'h19, 20);
    check("frame_val",   64'(digit_val), 64'h4321);
    check("frame_known", 64'(known),     64'hF);
    dwell(4'b1111, 8'hFF, 5);

    // glitch: only the return to 40 captures
    dwell(4'b1110, 8'h40, 5);
    dwell(4'b1110, 8'h00, 1);
    dwell(4'b1110, 8'h40, 20);

    // blank, unknown, dp-set, then completing digit 3
    dwell(4'b1011, 8'h7F, 20);
    dwell(4'b1011, 8'h55, 20);
    dwell(4'b1101, 8'h80, 20);
    dwell(4'b0111, 8'h0E, 20);

    // stale assertion and clearing on capture
    do_reset();
    r = cyc;
    wait_cyc(r + 15);
    check("stale_pre", 64'(stale), 64'h0);
    wait_cyc(r + 16);
    check("stale_set", 64'(stale), 64'h1);
    wait_cyc(r + 40);
    check("stale_hold", 64'(stale), 64'h1);
    d = cyc;
    start_dwell(4'b1110, 8'h40, 1'b1);
    wait_cyc(d + SC + 2);
    check("stale_before_cap", 64'(stale), 64'h1);
    wait_cyc(d + SC + 3);
    check("stale_cleared", 64'(stale), 64'h0);
    wait_cyc(d + 20);
    @(posedge clk);
    #1;
    dwell(4'b1111, 8'hFF, 4);

    // reset mid-frame discards the partial frame
    dwell(4'b1110, 8'h12, 20);
    dwell(4'b1101, 8'h02, 20);
    do_reset();
    dwell(4'b1011, 8'h78, 20);
    dwell(4'b0111, 8'h00, 20);
    dwell(4'b1110, 8'h10, 20);
    dwell(4'b1101, 8'h08, 20);

    // remaining glyphs, one more frame
    dwell(4'b1110, 8'h03, 20);
    dwell(4'b1101, 8'h46, 20);
    dwell(4'b1011, 8'h21, 20);
    dwell(4'b0111, 8'h06, 20);
    check("last_val", 64'(digit_val), 64'hEDCB);
    dwell(4'b1111, 8'hFF, 5);

    check("q_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
